// File: rtl/sample_byte_feeder_pkg.sv
// Shared types and helpers for the sample byte feeder: fetch FSM encoding,
// word geometry and the tick divider computation.
package sample_feeder_pkg;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_WAIT
  } fetch_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;

  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned rate_hz);
    return clk_hz / rate_hz;
  endfunction

endpackage

// File: rtl/sample_byte_feeder_if.sv
// Pipelined flash read bus (waitrequest / readdatavalid) between the feeder
// and the flash sample memory.
interface sample_byte_feeder_if #(
  parameter int unsigned ADDR_WIDTH = 23
);
  logic                  flash_mem_read;
  logic [ADDR_WIDTH-1:0] flash_mem_address;
  logic                  flash_mem_waitrequest;
  logic [31:0]           flash_mem_readdata;
  logic                  flash_mem_readdatavalid;

  modport master (
    output flash_mem_read,
    output flash_mem_address,
    input  flash_mem_waitrequest,
    input  flash_mem_readdata,
    input  flash_mem_readdatavalid
  );

  modport slave (
    input  flash_mem_read,
    input  flash_mem_address,
    output flash_mem_waitrequest,
    output flash_mem_readdata,
    output flash_mem_readdatavalid
  );
endinterface

// File: rtl/sample_byte_feeder_tick_gen.sv
// Sample-period divider: one-cycle tick every DIV enabled cycles; the count
// is held at zero while disabled.
module sample_tick_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/sample_byte_feeder.sv
// Fetches 32-bit sample words from flash into a two-slot buffer and emits one
// byte (little-endian) per sample tick with a one-cycle strobe.
module sample_byte_feeder
  import sample_feeder_pkg::*;
#(
  parameter int unsigned           CLK_FREQ_IN_HZ  = 25000000,
  parameter int unsigned           SAMPLE_RATE_HZ  = 22000,
  parameter int unsigned           ADDR_WIDTH      = 23,
  parameter logic [ADDR_WIDTH-1:0] START_WORD_ADDR = '0,
  parameter logic [ADDR_WIDTH-1:0] END_WORD_ADDR   = 'h7FFFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  sample_byte_feeder_if.master       flash,
  output logic [7:0]                 sample_byte,
  output logic                       sample_strobe,
  output logic                       underrun
);
  localparam int unsigned DIV = calc_div(CLK_FREQ_IN_HZ, SAMPLE_RATE_HZ);

  logic tick;

  sample_tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .tick  (tick)
  );

  fetch_state_t          state, state_next;
  logic                  read;
  logic                  capture;
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0]           cur_word, next_word;
  logic                  cur_valid, next_valid;
  logic [1:0]            idx;

  assign flash.flash_mem_read    = read;
  assign flash.flash_mem_address = address;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= F_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    read       = 1'b0;
    capture    = 1'b0;
    unique case (state)
      F_IDLE: begin
        if (enable && !next_valid) state_next = F_REQ;
      end
      F_REQ: begin
        read = 1'b1;
        if (!flash.flash_mem_waitrequest) state_next = F_WAIT;
      end
      F_WAIT: begin
        if (flash.flash_mem_readdatavalid) begin
          capture    = 1'b1;
          state_next = F_IDLE;
        end
      end
      default: state_next = F_IDLE;
    endcase
  end

  // Capture only happens while next_valid=0 and promotion only while
  // next_valid=1, so the two never both write the next slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      address       <= START_WORD_ADDR;
      cur_word      <= '0;
      next_word     <= '0;
      cur_valid     <= 1'b0;
      next_valid    <= 1'b0;
      idx           <= '0;
      sample_byte   <= '0;
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      sample_strobe <= 1'b0;

      if (capture) begin
        next_word  <= flash.flash_mem_readdata;
        next_valid <= 1'b1;
        address    <= (address == END_WORD_ADDR) ? START_WORD_ADDR
                                                 : address + ADDR_WIDTH'(1);
      end

      if (!cur_valid && next_valid) begin
        cur_word   <= next_word;
        cur_valid  <= 1'b1;
        idx        <= '0;
        next_valid <= 1'b0;
      end

      if (tick) begin
        if (cur_valid) begin
          sample_byte   <= cur_word[{idx, 3'b000} +: 8];
          sample_strobe <= 1'b1;
          idx           <= idx + 2'd1;
          if (idx == 2'(BYTES_PER_WORD - 1)) cur_valid <= 1'b0;
        end else begin
          underrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_byte_feeder.sv
// Scoreboard bench for sample_byte_feeder: directed scenarios push expected
// bytes, a monitor checks every strobe, a responder models the flash bus.
module tb_sample_byte_feeder;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] sample_byte;
  logic       sample_strobe;
  logic       underrun;

  sample_byte_feeder_if #(.ADDR_WIDTH(23)) bus ();

  sample_byte_feeder #(
    .CLK_FREQ_IN_HZ (100),
    .SAMPLE_RATE_HZ (10),
    .ADDR_WIDTH     (23),
    .START_WORD_ADDR(23'd0),
    .END_WORD_ADDR  (23'd2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .flash        (bus),
    .sample_byte  (sample_byte),
    .sample_strobe(sample_strobe),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  logic [31:0] mem [3];
  logic [7:0]  tbl [12];
  logic [7:0]  exp_q [$];

  // responder state
  int unsigned acc_n       = 0;
  int unsigned slow_idx    = 999;
  int unsigned slow_lat    = 1;
  int unsigned stall_idx   = 999;
  int unsigned stall_left  = 0;
  int unsigned countdown   = 0;
  bit          busy        = 0;
  bit          stalling    = 0;
  logic [22:0] stall_addr  = '0;
  logic [22:0] pend_addr   = '0;
  logic [22:0] addr_log [$];

  bit          spacing_chk = 0;
  bit          have_last   = 0;
  int unsigned last_cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Flash responder: drives all bus inputs on the falling edge.
  initial begin
    bus.flash_mem_waitrequest   = 1'b0;
    bus.flash_mem_readdatavalid = 1'b0;
    bus.flash_mem_readdata      = '0;
    forever begin
      @(negedge clk);
      bus.flash_mem_readdatavalid = 1'b0;
      if (busy && countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          bus.flash_mem_readdatavalid = 1'b1;
          bus.flash_mem_readdata      = mem[int'(pend_addr)];
          busy = 0;
        end
      end
      if (!busy && bus.flash_mem_read) begin
        if (acc_n == stall_idx && stall_left > 0) begin
          if (!stalling) begin
            stalling   = 1;
            stall_addr = bus.flash_mem_address;
          end else begin
            check("stall_addr_stable", 32'(bus.flash_mem_address), 32'(stall_addr));
          end
          bus.flash_mem_waitrequest = 1'b1;
          stall_left--;
        end else begin
          if (stalling) begin
            check("stall_addr_at_accept", 32'(bus.flash_mem_address), 32'(stall_addr));
            stalling = 0;
          end
          bus.flash_mem_waitrequest = 1'b0;
          addr_log.push_back(bus.flash_mem_address);
          pend_addr = bus.flash_mem_address;
          countdown = (acc_n == slow_idx) ? slow_lat : 1;
          busy      = 1;
          acc_n++;
        end
      end else begin
        bus.flash_mem_waitrequest = 1'b0;
      end
    end
  end

  // Monitor: every strobe must match the head of the expected queue.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (sample_strobe) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_strobe: got byte %h, required no strobe (cycle %0d)",
                   sample_byte, cyc);
        end else begin
          e = exp_q.pop_front();
          check("sample_byte", 32'(sample_byte), 32'(e));
        end
        if (spacing_chk && have_last) check("strobe_spacing", cyc - last_cyc, 10);
        last_cyc  = cyc;
        have_last = 1;
      end
    end
  end

  task automatic push_bytes(input int unsigned first, input int unsigned count);
    for (int unsigned i = 0; i < count; i++) exp_q.push_back(tbl[(first + i) % 12]);
  endtask

  task automatic wait_drain(input int unsigned max, input string name);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d bytes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_acc(input int unsigned target, input int unsigned max, input string name);
    int unsigned n = 0;
    while (acc_n < target && n < max) begin
      @(negedge clk);
      n++;
    end
    if (acc_n < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d accepts, required %0d", name, acc_n, target);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    addr_log.delete();
    acc_n       = 0;
    busy        = 0;
    countdown   = 0;
    stalling    = 0;
    stall_left  = 0;
    stall_idx   = 999;
    slow_idx    = 999;
    spacing_chk = 0;
    have_last   = 0;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned rd_seen;
    int unsigned n;
    mem[0] = 32'h44332211;
    mem[1] = 32'h88776655;
    mem[2] = 32'hCCBBAA99;
    tbl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
            8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    reset  = 1'b1;
    enable = 1'b0;

    // Reset state
    do_reset();
    check("rst_sample_byte", 32'(sample_byte), 0);
    check("rst_strobe", 32'(sample_strobe), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_read", 32'(bus.flash_mem_read), 0);
    check("rst_address", 32'(bus.flash_mem_address), 0);

    // Continuous stream, 13 bytes, wrap of the address range
    push_bytes(0, 13);
    spacing_chk = 1;
    enable = 1'b1;
    wait_drain(200, "stream");
    spacing_chk = 0;
    check("stream_underrun", 32'(underrun), 0);
    check("addr_log_len_ge4", 32'(addr_log.size() >= 4), 1);
    if (addr_log.size() >= 4) begin
      check("addr_seq0", 32'(addr_log[0]), 0);
      check("addr_seq1", 32'(addr_log[1]), 1);
      check("addr_seq2", 32'(addr_log[2]), 2);
      check("addr_seq3", 32'(addr_log[3]), 0);
    end

    // Waitrequest stall on the second request
    do_reset();
    stall_idx  = 1;
    stall_left = 5;
    push_bytes(0, 8);
    enable = 1'b1;
    wait_drain(120, "stall");
    check("stall_consumed", stall_left, 0);
    check("stall_underrun", 32'(underrun), 0);

    // Late data on the second word forces an underrun
    do_reset();
    slow_idx = 1;
    slow_lat = 61;
    push_bytes(0, 4);
    enable = 1'b1;
    wait_drain(80, "pre_underrun");
    repeat (20) @(negedge clk);
    check("underrun_set", 32'(underrun), 1);
    check("underrun_hold_byte", 32'(sample_byte), 32'h44);
    push_bytes(4, 4);
    wait_drain(80, "post_underrun");
    check("underrun_sticky", 32'(underrun), 1);

    // Enable dropped while the third read is in flight
    do_reset();
    slow_idx = 2;
    slow_lat = 15;
    push_bytes(0, 4);
    enable = 1'b1;
    wait_acc(3, 100, "dis_acc");
    @(negedge clk);
    enable = 1'b0;
    wait_drain(5, "dis_pre");
    rd_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.flash_mem_read) rd_seen++;
    end
    check("dis_no_read", rd_seen, 0);
    check("dis_inflight_done", 32'(busy), 0);
    check("dis_accepts", acc_n, 3);
    push_bytes(4, 4);
    enable = 1'b1;
    wait_drain(60, "reenable");

    // Reset while the third read waits for data; the late pulse is ignored
    do_reset();
    slow_idx = 2;
    slow_lat = 20;
    push_bytes(0, 4);
    enable = 1'b1;
    wait_acc(3, 100, "rst_acc");
    @(negedge clk);
    check("wait_read_low", 32'(bus.flash_mem_read), 0);
    check("wait_address", 32'(bus.flash_mem_address), 2);
    reset  = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    check("midrst_read", 32'(bus.flash_mem_read), 0);
    check("midrst_address", 32'(bus.flash_mem_address), 0);
    check("midrst_sample_byte", 32'(sample_byte), 0);
    check("midrst_strobe", 32'(sample_strobe), 0);
    check("midrst_underrun", 32'(underrun), 0);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("late_pulse_delivered", 32'(busy), 0);
    repeat (3) @(negedge clk);
    check("post_pulse_address", 32'(bus.flash_mem_address), 0);
    check("post_pulse_read", 32'(bus.flash_mem_read), 0);
    check("post_pulse_sample_byte", 32'(sample_byte), 0);
    push_bytes(0, 4);
    enable = 1'b1;
    wait_drain(80, "post_reset_stream");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
